// File: rtl/gcd_controller_if.sv
// Control/status bundle between the GCD controller, its datapath and the system.
// master = controller side, slave = datapath/system side.
interface gcd_controller_if #(
   parameter int ITER_W = 8
);
   logic              start;
   logic              x_lt_y;
   logic              x_neq_y;
   logic              x_ld;
   logic              y_ld;
   logic              x_sel;
   logic              y_sel;
   logic              d_o_ld;
   logic              busy;
   logic              done;
   logic              err;
   logic [ITER_W-1:0] iter_count;

   modport master (
      input  start, x_lt_y, x_neq_y,
      output x_ld, y_ld, x_sel, y_sel, d_o_ld, busy, done, err, iter_count
   );

   modport slave (
      output start, x_lt_y, x_neq_y,
      input  x_ld, y_ld, x_sel, y_sel, d_o_ld, busy, done, err, iter_count
   );
endinterface

// File: rtl/gcd_controller.sv
// Moore FSM sequencing a subtract-and-compare GCD datapath.
// Optional step limit with error reporting is enabled by defining GCD_TIMEOUT_EN.
module gcd_controller #(
   parameter int ITER_W   = 8,
   parameter int MAX_ITER = 255
) (
   input  logic              clk,
   input  logic              reset,
   gcd_controller_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_SUB_X,
      S_SUB_Y,
      S_OUTPUT,
      S_DONE,
      S_DONE_ERR
   } state_t;

   if (MAX_ITER > (2**ITER_W) - 1) begin : g_bad_max_iter
      $error("MAX_ITER does not fit in iter_count");
   end

`ifdef GCD_TIMEOUT_EN
   localparam logic [ITER_W-1:0] LP_MAX = ITER_W'(MAX_ITER);
`endif

   state_t            r_state;
   state_t            w_next;
   logic [ITER_W-1:0] r_iter;

   logic w_x_ld, w_y_ld, w_x_sel, w_y_sel, w_d_o_ld, w_busy, w_done, w_err;

   // The counter holds at all-ones so a runaway run still reports a meaningful value.
   function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
      return (&v) ? v : v + ITER_W'(1);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                r_iter <= '0;
      else if (r_state == S_IDLE && bus.start)  r_iter <= '0;
      else if (r_state == S_SUB_X || r_state == S_SUB_Y)
                                                r_iter <= sat_inc(r_iter);
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (bus.start) w_next = S_LOAD;
         S_LOAD:     w_next = S_CHECK;
         S_CHECK: begin
            if (!bus.x_neq_y)       w_next = S_OUTPUT;
`ifdef GCD_TIMEOUT_EN
            else if (r_iter == LP_MAX) w_next = S_DONE_ERR;
`endif
            else if (bus.x_lt_y)    w_next = S_SUB_Y;
            else                    w_next = S_SUB_X;
         end
         S_SUB_X:    w_next = S_CHECK;
         S_SUB_Y:    w_next = S_CHECK;
         S_OUTPUT:   w_next = S_DONE;
         S_DONE:     w_next = S_IDLE;
         S_DONE_ERR: w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_x_ld   = 1'b0;
      w_y_ld   = 1'b0;
      w_x_sel  = 1'b0;
      w_y_sel  = 1'b0;
      w_d_o_ld = 1'b0;
      w_busy   = (r_state != S_IDLE);
      w_done   = 1'b0;
      w_err    = 1'b0;
      case (r_state)
         S_LOAD: begin
            w_x_ld = 1'b1;
            w_y_ld = 1'b1;
         end
         S_SUB_X: begin
            w_x_ld  = 1'b1;
            w_x_sel = 1'b1;
         end
         S_SUB_Y: begin
            w_y_ld  = 1'b1;
            w_y_sel = 1'b1;
         end
         S_OUTPUT:   w_d_o_ld = 1'b1;
         S_DONE:     w_done   = 1'b1;
         S_DONE_ERR: begin
            w_done = 1'b1;
`ifdef GCD_TIMEOUT_EN
            w_err  = 1'b1;
`else
            w_err  = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   assign bus.x_ld       = w_x_ld;
   assign bus.y_ld       = w_y_ld;
   assign bus.x_sel      = w_x_sel;
   assign bus.y_sel      = w_y_sel;
   assign bus.d_o_ld     = w_d_o_ld;
   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.err        = w_err;
   assign bus.iter_count = r_iter;

endmodule
